// File: rtl/egress_meta_merge_if.sv
// Egress AXI-stream bus carrying packet beats plus per-packet metadata on the first beat.
interface axi_stream_vnp4_if;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned KEEP_W = 64;
    localparam int unsigned PORT_W = 16;
    localparam int unsigned SIZE_W = 16;

    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              valid;
    logic              user_valid;
    logic [PORT_W-1:0] user_ingress_port;
    logic [PORT_W-1:0] user_egress_port;
    logic [SIZE_W-1:0] user_size;
    logic              ready;

    modport master (
        output data, keep, last, valid, user_valid,
               user_ingress_port, user_egress_port, user_size,
        input  ready
    );

    modport slave (
        input  data, keep, last, valid, user_valid,
               user_ingress_port, user_egress_port, user_size,
        output ready
    );
endinterface

// File: rtl/egress_meta_merge.sv
// Pairs each metadata word with one packet, forwarding or discarding the packet beats
// and attaching the metadata to the first forwarded beat.
module egress_meta_merge #(
    parameter int unsigned MAX_PORT = 9,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [511:0]       s_axis_tdata,
    input  logic [63:0]        s_axis_tkeep,
    input  logic               s_axis_tlast,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic [15:0]        s_meta_ingress_port,
    input  logic [15:0]        s_meta_egress_port,
    input  logic [15:0]        s_meta_size,
    input  logic               s_meta_drop,
    input  logic               s_meta_valid,
    output logic               s_meta_ready,
    axi_stream_vnp4_if.master  m_axis,
    output logic [CNT_W-1:0]   stat_pkt_cnt,
    output logic [CNT_W-1:0]   stat_drop_cnt
);
    localparam int unsigned DATA_W = 512;
    localparam int unsigned KEEP_W = 64;
    localparam int unsigned PORT_W = 16;
    localparam int unsigned SIZE_W = 16;

    typedef enum logic [1:0] {
        META = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t              state;
    logic                meta_rdy;
    logic                first;
    logic [PORT_W-1:0]   lat_ingress;
    logic [PORT_W-1:0]   lat_egress;
    logic [SIZE_W-1:0]   lat_size;

    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [KEEP_W-1:0]   out_keep;
    logic                out_last;
    logic                out_uvalid;
    logic [PORT_W-1:0]   out_uingress;
    logic [PORT_W-1:0]   out_uegress;
    logic [SIZE_W-1:0]   out_usize;

    logic                meta_hs;
    logic                meta_bad;
    logic                out_load;
    logic                beat_hs;
    logic                fwd_beat;
    logic                drop_beat;

    // Handshake decode; output stage may load when empty or draining
    assign meta_hs   = s_meta_valid && meta_rdy;
    assign meta_bad  = s_meta_drop
                     || (s_meta_egress_port[3:0] > 4'(MAX_PORT))
                     || (|s_meta_egress_port[15:4]);
    assign out_load  = !out_valid || m_axis.ready;
    assign beat_hs   = s_axis_tvalid && s_axis_tready;
    assign fwd_beat  = beat_hs && (state == FWD);
    assign drop_beat = beat_hs && (state == DROP);

    assign s_meta_ready  = meta_rdy;
    assign s_axis_tready = ((state == FWD) && out_load) || (state == DROP);

    // Packet sequencing FSM with latched metadata
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= META;
            meta_rdy    <= 1'b0;
            first       <= 1'b0;
            lat_ingress <= '0;
            lat_egress  <= '0;
            lat_size    <= '0;
        end else begin
            case (state)
                META: begin
                    if (meta_hs) begin
                        lat_ingress <= s_meta_ingress_port;
                        lat_egress  <= s_meta_egress_port;
                        lat_size    <= s_meta_size;
                        first       <= 1'b1;
                        meta_rdy    <= 1'b0;
                        state       <= meta_bad ? DROP : FWD;
                    end else begin
                        meta_rdy    <= 1'b1;
                    end
                end
                FWD: begin
                    if (fwd_beat) begin
                        first <= 1'b0;
                        if (s_axis_tlast) begin
                            state    <= META;
                            meta_rdy <= 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (drop_beat && s_axis_tlast) begin
                        state    <= META;
                        meta_rdy <= 1'b1;
                    end
                end
                default: begin
                    state    <= META;
                    meta_rdy <= 1'b0;
                end
            endcase
        end
    end

    // Single output register stage; holds while the sink stalls
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_keep     <= '0;
            out_last     <= 1'b0;
            out_uvalid   <= 1'b0;
            out_uingress <= '0;
            out_uegress  <= '0;
            out_usize    <= '0;
        end else if (out_load) begin
            out_valid <= fwd_beat;
            if (fwd_beat) begin
                out_data     <= s_axis_tdata;
                out_keep     <= s_axis_tkeep;
                out_last     <= s_axis_tlast;
                out_uvalid   <= first;
                out_uingress <= first ? lat_ingress : '0;
                out_uegress  <= first ? lat_egress  : '0;
                out_usize    <= first ? lat_size    : '0;
            end
        end
    end

    assign m_axis.valid             = out_valid;
    assign m_axis.data              = out_data;
    assign m_axis.keep              = out_keep;
    assign m_axis.last              = out_last;
    assign m_axis.user_valid        = out_uvalid;
    assign m_axis.user_ingress_port = out_uingress;
    assign m_axis.user_egress_port  = out_uegress;
    assign m_axis.user_size         = out_usize;

    // Saturating forwarded/dropped packet counters, bumped on the tlast beat
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_pkt_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (fwd_beat && s_axis_tlast && (stat_pkt_cnt != {CNT_W{1'b1}})) begin
                stat_pkt_cnt <= stat_pkt_cnt + CNT_W'(1);
            end
            if (drop_beat && s_axis_tlast && (stat_drop_cnt != {CNT_W{1'b1}})) begin
                stat_drop_cnt <= stat_drop_cnt + CNT_W'(1);
            end
        end
    end
endmodule
